// File: rtl/me_scheduler_pkg.sv
// Shared definitions for the motion-estimation block scheduler:
// sequencer state encoding, pixel/result widths and block-size derived constants.
package me_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STREAM = 3'd1,
        S_WAIT   = 3'd2,
        S_OUT    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int PIX_W = 8;
    localparam int RES_W = 8;

    function automatic int bs_sq(input int bs);
        return bs * bs;
    endfunction

    function automatic int bs_cube(input int bs);
        return bs * bs * bs;
    endfunction

endpackage

// File: rtl/me_scheduler_addr_gen.sv
// Block/pixel walker: t, bx, by counters and the current/reference address arithmetic.
module me_addr_gen
    import me_scheduler_pkg::*;
#(
    parameter int BLK_SIZE = 4,
    parameter int FRAME_W  = 16,
    parameter int FRAME_H  = 16,
    parameter int ADDR_W   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_step,
    input  logic              i_next_blk,
    output logic              o_t_first,
    output logic              o_t_last,
    output logic              o_blk_last,
    output logic [ADDR_W-1:0] o_cur_addr,
    output logic [ADDR_W-1:0] o_ref_addr,
    output logic [ADDR_W-1:0] o_blk_idx
);

    localparam int BS_SQ   = bs_sq(BLK_SIZE);
    localparam int BS_CUBE = bs_cube(BLK_SIZE);
    localparam int NBX     = FRAME_W / BLK_SIZE;
    localparam int NBY     = FRAME_H / BLK_SIZE;
    localparam int T_W     = $clog2(BS_CUBE) + 1;
    localparam int BX_W    = $clog2(NBX) + 1;
    localparam int BY_W    = $clog2(NBY) + 1;

    localparam logic [31:0] BS_U  = 32'(BLK_SIZE);
    localparam logic [31:0] SQ_U  = 32'(BS_SQ);
    localparam logic [31:0] FW_U  = 32'(FRAME_W);
    localparam logic [31:0] NBX_U = 32'(NBX);

    logic [T_W-1:0]  r_t;
    logic [BX_W-1:0] r_bx;
    logic [BY_W-1:0] r_by;

    logic        w_bx_last;
    logic        w_by_last;
    logic [31:0] w_t32;
    logic [31:0] w_x;
    logic [31:0] w_y;
    logic [31:0] w_z;
    logic [31:0] w_y_ref;
    logic [31:0] w_row_base;
    logic [31:0] w_col;

    assign w_bx_last  = (r_bx == BX_W'(NBX - 1));
    assign w_by_last  = (r_by == BY_W'(NBY - 1));
    assign o_t_first  = (r_t == '0);
    assign o_t_last   = (r_t == T_W'(BS_CUBE - 1));
    assign o_blk_last = w_bx_last && w_by_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_t  <= '0;
            r_bx <= '0;
            r_by <= '0;
        end else if (i_clear) begin
            r_t  <= '0;
            r_bx <= '0;
            r_by <= '0;
        end else begin
            if (i_step) begin
                r_t <= o_t_last ? '0 : r_t + 1'b1;
            end
            if (i_next_blk) begin
                if (w_bx_last) begin
                    r_bx <= '0;
                    r_by <= w_by_last ? '0 : r_by + 1'b1;
                end else begin
                    r_bx <= r_bx + 1'b1;
                end
            end
        end
    end

    // Power-of-two block edge: the divides and modulos reduce to bit slices.
    assign w_t32      = 32'(r_t);
    assign w_x        = w_t32 % BS_U;
    assign w_y        = (w_t32 / BS_U) % BS_U;
    assign w_z        = w_t32 / SQ_U;
    assign w_y_ref    = (w_y + w_z) % BS_U;
    assign w_row_base = 32'(r_by) * BS_U;
    assign w_col      = 32'(r_bx) * BS_U + w_x;

    assign o_cur_addr = ADDR_W'((w_row_base + w_y) * FW_U + w_col);
    assign o_ref_addr = ADDR_W'((w_row_base + w_y_ref) * FW_U + w_col);
    assign o_blk_idx  = ADDR_W'(32'(r_by) * NBX_U + 32'(r_bx));

endmodule

// File: rtl/me_scheduler.sv
// Frame sequencer for one ME PE row: streams block pixels, collects per-block results.
// Optional WAIT-state watchdog is built only when ME_TIMEOUT_EN is defined.
module me_scheduler
    import me_scheduler_pkg::*;
#(
    parameter int BLK_SIZE = 4,
    parameter int FRAME_W  = 16,
    parameter int FRAME_H  = 16,
    parameter int ADDR_W   = 8,
    parameter int TIMEOUT  = 1023
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_go,
    output logic              o_busy,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_cur_addr,
    output logic [ADDR_W-1:0] o_ref_addr,
    input  logic [PIX_W-1:0]  i_cur_data,
    input  logic [PIX_W-1:0]  i_ref_data,
    input  logic [PIX_W-1:0]  i_ref2_data,
    output logic [PIX_W-1:0]  o_row_c,
    output logic [PIX_W-1:0]  o_row_p,
    output logic [PIX_W-1:0]  o_row_pp,
    output logic              o_row_start,
    input  logic              i_row_done,
    input  logic [RES_W-1:0]  i_row_mme,
    input  logic [RES_W-1:0]  i_row_mi,
    input  logic [RES_W-1:0]  i_row_mj,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [ADDR_W-1:0] o_res_blk,
    output logic [RES_W-1:0]  o_res_mme,
    output logic [RES_W-1:0]  o_res_mi,
    output logic [RES_W-1:0]  o_res_mj,
    output logic              o_err
);

    state_t r_state;
    state_t w_next;

    logic              w_rd_en;
    logic              w_clear;
    logic              w_next_blk;
    logic              w_capture;
    logic              w_to_hit;
    logic              w_t_first;
    logic              w_t_last;
    logic              w_blk_last;
    logic [ADDR_W-1:0] w_blk_idx;

    logic              r_rd_d1;
    logic              r_first_d1;
    logic [PIX_W-1:0]  r_row_c;
    logic [PIX_W-1:0]  r_row_p;
    logic [PIX_W-1:0]  r_row_pp;
    logic              r_row_start;
    logic [ADDR_W-1:0] r_res_blk;
    logic [RES_W-1:0]  r_res_mme;
    logic [RES_W-1:0]  r_res_mi;
    logic [RES_W-1:0]  r_res_mj;

    me_addr_gen #(
        .BLK_SIZE (BLK_SIZE),
        .FRAME_W  (FRAME_W),
        .FRAME_H  (FRAME_H),
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clear    (w_clear),
        .i_step     (w_rd_en),
        .i_next_blk (w_next_blk),
        .o_t_first  (w_t_first),
        .o_t_last   (w_t_last),
        .o_blk_last (w_blk_last),
        .o_cur_addr (o_cur_addr),
        .o_ref_addr (o_ref_addr),
        .o_blk_idx  (w_blk_idx)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_clear    = 1'b0;
        w_next_blk = 1'b0;
        w_capture  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_go) begin
                    w_next  = S_STREAM;
                    w_clear = 1'b1;
                end
            end
            S_STREAM: begin
                if (w_t_last) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_row_done) begin
                    w_capture = 1'b1;
                    w_next    = S_OUT;
                end else if (w_to_hit) begin
                    w_next = S_IDLE;
                end
            end
            S_OUT: begin
                if (i_res_ready) begin
                    w_next_blk = 1'b1;
                    w_next     = w_blk_last ? S_DONE : S_STREAM;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_rd_en     = (r_state == S_STREAM);
    assign o_rd_en     = w_rd_en;
    assign o_busy      = (r_state != S_IDLE);
    assign o_res_valid = (r_state == S_OUT);

    // Memory data lands one cycle after rd_en; register it once more for the row.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_d1     <= 1'b0;
            r_first_d1  <= 1'b0;
            r_row_c     <= '0;
            r_row_p     <= '0;
            r_row_pp    <= '0;
            r_row_start <= 1'b0;
        end else begin
            r_rd_d1     <= w_rd_en;
            r_first_d1  <= w_rd_en && w_t_first;
            r_row_start <= r_first_d1;
            if (r_rd_d1) begin
                r_row_c  <= i_cur_data;
                r_row_p  <= i_ref_data;
                r_row_pp <= i_ref2_data;
            end
        end
    end

    assign o_row_c     = r_row_c;
    assign o_row_p     = r_row_p;
    assign o_row_pp    = r_row_pp;
    assign o_row_start = r_row_start;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_res_blk <= '0;
            r_res_mme <= '0;
            r_res_mi  <= '0;
            r_res_mj  <= '0;
        end else if (w_capture) begin
            r_res_blk <= w_blk_idx;
            r_res_mme <= i_row_mme;
            r_res_mi  <= i_row_mi;
            r_res_mj  <= i_row_mj;
        end
    end

    assign o_res_blk = r_res_blk;
    assign o_res_mme = r_res_mme;
    assign o_res_mi  = r_res_mi;
    assign o_res_mj  = r_res_mj;

`ifdef ME_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;

    assign w_to_hit = (r_to_cnt == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_to_cnt <= (r_state == S_WAIT) ? r_to_cnt - 1'b1 : TO_W'(TIMEOUT - 1);
            if ((r_state == S_WAIT) && !i_row_done && w_to_hit) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_err = r_err;
`else
    assign w_to_hit = 1'b0;
    // No watchdog: the comparison is constant false for any legal TIMEOUT.
    assign o_err    = (TIMEOUT < 0);
`endif

endmodule
